// File: rtl/pin_io_pkg.sv
// Shared definitions for the pin-echo fixture: bus widths and the capture FSM encoding.
package pin_io_pkg;
  localparam int PIN_W      = 6;
  localparam int DIG_W      = 12;
  localparam int MAX_LOG2_N = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } cap_state_t;
endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for an asynchronous bus; shared by the capture and echo drive sides.
module pin_sync #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/pin_in_capture.sv
// Settles, then accumulates 2^LOG2_N synchronized pin samples into a 12-bit result with valid/ready.
// Build option: PIN_IN_CAPTURE_AVG_EN presents the mean (sum >> LOG2_N) instead of the raw sum.
module pin_in_capture
  import pin_io_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_DIV    = 4,
  parameter int LOG2_N        = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic [PIN_W-1:0] analog,
  output logic [DIG_W-1:0] digital,
  output logic             valid,
  input  logic             ready
);
  localparam int             LOG2_EFF    = (LOG2_N > MAX_LOG2_N) ? MAX_LOG2_N : LOG2_N;
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]     DIV_LAST    = 8'(SAMPLE_DIV - 1);
  localparam logic [6:0]     N_SMP       = 7'(1 << LOG2_EFF);

  logic [PIN_W-1:0] analog_s;
  cap_state_t       state;
  logic [DIG_W-1:0] acc;
  logic [7:0]       settle_cnt;
  logic [7:0]       div_cnt;
  logic [6:0]       smp_cnt;
  logic [6:0]       smp_nxt;

  function automatic logic [DIG_W-1:0] scale_result(input logic [DIG_W-1:0] sum);
`ifdef PIN_IN_CAPTURE_AVG_EN
    return sum >> LOG2_EFF;
`else
    return sum;
`endif
  endfunction

  pin_sync #(.DATA_W(PIN_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (analog),
    .q     (analog_s)
  );

  // Sample count including the one taken this cycle, so the last period ends exactly on N
  assign smp_nxt = smp_cnt + 7'(div_cnt == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      digital    <= '0;
      acc        <= '0;
      settle_cnt <= '0;
      div_cnt    <= '0;
      smp_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            settle_cnt <= '0;
            div_cnt    <= '0;
            smp_cnt    <= '0;
            busy       <= 1'b1;
            state      <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (div_cnt == 8'd0) begin
            acc     <= acc + DIG_W'(analog_s);
            smp_cnt <= smp_nxt;
          end
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (smp_nxt == N_SMP) state <= DONE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          // Result is registered one cycle after entry; it then holds until the handshake
          if (!valid) begin
            valid   <= 1'b1;
            digital <= scale_result(acc);
          end else if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
